// File: rtl/exception_unit.sv
// Machine-mode trap controller: prioritises exceptions, interrupts and mret, forms CSR write data
// and sequences redirect/flush through IDLE -> ENTER -> DRAIN. Optional macro: EXC_UNIT_IRQ_SYNC_EN.
module exception_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] inst_i,
    input  logic [XLEN-1:0] badaddr_i,
    input  logic            e_inst_misaligned_i,
    input  logic            e_illegal_inst_i,
    input  logic            e_ebreak_i,
    input  logic            e_ecall_i,
    input  logic            e_ld_misaligned_i,
    input  logic            e_st_misaligned_i,
    input  logic            is_mret_i,
    input  logic            irq_ext_i,
    input  logic            irq_timer_i,
    input  logic            irq_sw_i,
    input  logic [XLEN-1:0] mstatus_i,
    input  logic [XLEN-1:0] mie_i,
    input  logic [XLEN-1:0] mepc_i,
    input  logic [XLEN-1:0] mcause_i,
    input  logic [XLEN-1:0] mtval_i,
    output logic            we_exc_o,
    output logic [XLEN-1:0] mcause_d_o,
    output logic [XLEN-1:0] mepc_d_o,
    output logic [XLEN-1:0] mtval_d_o,
    output logic [XLEN-1:0] mstatus_d_o,
    output logic [XLEN-1:0] mip_d_o,
    output logic            is_int_o,
    output logic            sel_exc_nret_o,
    output logic            redirect_o,
    output logic            flush_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTER = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e state_q, state_d;

    // Pending bits: [2] ext, [1] timer, [0] sw
    logic [2:0] irq_raw;
    logic [2:0] pend_q;

`ifdef EXC_UNIT_IRQ_SYNC_EN
    // First synchroniser stage; pend_q acts as the second stage.
    logic [2:0] irq_meta_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irq_meta_q <= '0;
        end else begin
            irq_meta_q <= {irq_ext_i, irq_timer_i, irq_sw_i};
        end
    end

    assign irq_raw = irq_meta_q;
`else
    assign irq_raw = {irq_ext_i, irq_timer_i, irq_sw_i};
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q <= '0;
        end else begin
            pend_q <= irq_raw;
        end
    end

    logic int_ext, int_timer, int_sw, any_int, any_exc, trap_ev, mret_ev;

    assign int_ext   = mstatus_i[3] & mie_i[11] & pend_q[2];
    assign int_timer = mstatus_i[3] & mie_i[7]  & pend_q[1];
    assign int_sw    = mstatus_i[3] & mie_i[3]  & pend_q[0];
    assign any_int   = int_ext | int_timer | int_sw;
    assign any_exc   = e_inst_misaligned_i | e_illegal_inst_i | e_ebreak_i |
                       e_ecall_i | e_ld_misaligned_i | e_st_misaligned_i;
    assign trap_ev   = valid_i & (any_exc | any_int);
    assign mret_ev   = valid_i & is_mret_i;

    logic [XLEN-1:0] int_cause, exc_cause, exc_tval, trap_cause, trap_tval;
    logic [XLEN-1:0] trap_mstatus, mret_mstatus;

    always_comb begin
        int_cause = '0;
        if (int_ext) begin
            int_cause = 32'h8000_000B;
        end else if (int_sw) begin
            int_cause = 32'h8000_0003;
        end else if (int_timer) begin
            int_cause = 32'h8000_0007;
        end
    end

    always_comb begin
        exc_cause = '0;
        exc_tval  = '0;
        if (e_inst_misaligned_i) begin
            exc_cause = 32'd0;
            exc_tval  = badaddr_i;
        end else if (e_illegal_inst_i) begin
            exc_cause = 32'd2;
            exc_tval  = inst_i;
        end else if (e_ebreak_i) begin
            exc_cause = 32'd3;
        end else if (e_ecall_i) begin
            exc_cause = 32'd11;
        end else if (e_ld_misaligned_i) begin
            exc_cause = 32'd4;
            exc_tval  = badaddr_i;
        end else if (e_st_misaligned_i) begin
            exc_cause = 32'd6;
            exc_tval  = badaddr_i;
        end
    end

    assign trap_cause = any_int ? int_cause : exc_cause;
    assign trap_tval  = any_int ? '0 : exc_tval;

    always_comb begin
        trap_mstatus        = mstatus_i;
        trap_mstatus[7]     = mstatus_i[3];
        trap_mstatus[3]     = 1'b0;
        trap_mstatus[12:11] = 2'b11;
        mret_mstatus        = mstatus_i;
        mret_mstatus[3]     = mstatus_i[7];
        mret_mstatus[7]     = 1'b1;
        mret_mstatus[12:11] = 2'b11;
    end

    logic            we_q, we_d, is_int_q, is_int_d, sel_q, sel_d;
    logic            redir_q, redir_d, flush_q, flush_d;
    logic [XLEN-1:0] mcause_q, mcause_d, mepc_q, mepc_d, mtval_q, mtval_d, mstatus_q, mstatus_d;

    always_comb begin
        state_d   = state_q;
        we_d      = 1'b0;
        is_int_d  = 1'b0;
        sel_d     = 1'b0;
        redir_d   = 1'b0;
        flush_d   = 1'b0;
        mcause_d  = mcause_q;
        mepc_d    = mepc_q;
        mtval_d   = mtval_q;
        mstatus_d = mstatus_q;
        unique case (state_q)
            IDLE: begin
                if (trap_ev || mret_ev) begin
                    state_d = ENTER;
                    we_d    = 1'b1;
                    redir_d = 1'b1;
                    flush_d = 1'b1;
                    if (trap_ev) begin
                        is_int_d  = any_int;
                        mcause_d  = trap_cause;
                        mepc_d    = pc_i;
                        mtval_d   = trap_tval;
                        mstatus_d = trap_mstatus;
                    end else begin
                        sel_d     = 1'b1;
                        mcause_d  = mcause_i;
                        mepc_d    = mepc_i;
                        mtval_d   = mtval_i;
                        mstatus_d = mret_mstatus;
                    end
                end
            end
            ENTER: begin
                state_d = DRAIN;
                flush_d = 1'b1;
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            is_int_q  <= 1'b0;
            sel_q     <= 1'b0;
            redir_q   <= 1'b0;
            flush_q   <= 1'b0;
            mcause_q  <= '0;
            mepc_q    <= '0;
            mtval_q   <= '0;
            mstatus_q <= '0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            is_int_q  <= is_int_d;
            sel_q     <= sel_d;
            redir_q   <= redir_d;
            flush_q   <= flush_d;
            mcause_q  <= mcause_d;
            mepc_q    <= mepc_d;
            mtval_q   <= mtval_d;
            mstatus_q <= mstatus_d;
        end
    end

    assign we_exc_o       = we_q;
    assign is_int_o       = is_int_q;
    assign sel_exc_nret_o = sel_q;
    assign redirect_o     = redir_q;
    assign flush_o        = flush_q;
    assign mcause_d_o     = mcause_q;
    assign mepc_d_o       = mepc_q;
    assign mtval_d_o      = mtval_q;
    assign mstatus_d_o    = mstatus_q;
    assign mip_d_o        = {20'b0, pend_q[2], 3'b0, pend_q[1], 3'b0, pend_q[0], 3'b0};

    logic unused_mie_bits;
    assign unused_mie_bits = ^{mie_i[31:12], mie_i[10:8], mie_i[6:4], mie_i[2:0]};

endmodule

// File: tb/tb_exception_unit.sv
// Scoreboard bench for exception_unit: expected CSR writes are queued at stimulus time
// and popped when the ENTER-cycle strobe appears.
module tb_exception_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [31:0] pc_i, inst_i, badaddr_i;
    logic        e_inst_misaligned_i, e_illegal_inst_i, e_ebreak_i, e_ecall_i;
    logic        e_ld_misaligned_i, e_st_misaligned_i, is_mret_i;
    logic        irq_ext_i, irq_timer_i, irq_sw_i;
    logic [31:0] mstatus_i, mie_i, mepc_i, mcause_i, mtval_i;
    logic        we_exc_o, is_int_o, sel_exc_nret_o, redirect_o, flush_o;
    logic [31:0] mcause_d_o, mepc_d_o, mtval_d_o, mstatus_d_o, mip_d_o;

    exception_unit #(.XLEN(32)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .pc_i(pc_i), .inst_i(inst_i),
        .badaddr_i(badaddr_i), .e_inst_misaligned_i(e_inst_misaligned_i),
        .e_illegal_inst_i(e_illegal_inst_i), .e_ebreak_i(e_ebreak_i), .e_ecall_i(e_ecall_i),
        .e_ld_misaligned_i(e_ld_misaligned_i), .e_st_misaligned_i(e_st_misaligned_i),
        .is_mret_i(is_mret_i), .irq_ext_i(irq_ext_i), .irq_timer_i(irq_timer_i),
        .irq_sw_i(irq_sw_i), .mstatus_i(mstatus_i), .mie_i(mie_i), .mepc_i(mepc_i),
        .mcause_i(mcause_i), .mtval_i(mtval_i), .we_exc_o(we_exc_o),
        .mcause_d_o(mcause_d_o), .mepc_d_o(mepc_d_o), .mtval_d_o(mtval_d_o),
        .mstatus_d_o(mstatus_d_o), .mip_d_o(mip_d_o), .is_int_o(is_int_o),
        .sel_exc_nret_o(sel_exc_nret_o), .redirect_o(redirect_o), .flush_o(flush_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic        is_int;
        logic        sel;
        logic        redir;
        logic        flush;
        logic [31:0] mcause;
        logic [31:0] mepc;
        logic [31:0] mtval;
        logic [31:0] mstatus;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Exception priority table: flags {inst_mis, illegal, ebreak, ecall, ld_mis, st_mis}
    logic [5:0]  prio_flags[6] = '{6'b111111, 6'b011111, 6'b001110, 6'b000111, 6'b000011, 6'b000001};
    logic [31:0] prio_cause[6] = '{32'd0, 32'd2, 32'd3, 32'd11, 32'd4, 32'd6};
    logic [31:0] prio_tval[6]  = '{32'h0000_1234, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0000_1234, 32'h0000_1234};

    function automatic obs_t snap();
        return {we_exc_o, is_int_o, sel_exc_nret_o, redirect_o, flush_o,
                mcause_d_o, mepc_d_o, mtval_d_o, mstatus_d_o};
    endfunction

    function automatic obs_t mk(logic is_int, logic sel, logic [31:0] cause, logic [31:0] epc,
                                logic [31:0] tval, logic [31:0] ms);
        return {1'b1, is_int, sel, 1'b1, 1'b1, cause, epc, tval, ms};
    endfunction

    task automatic clear_inputs();
        valid_i = 1'b0; is_mret_i = 1'b0;
        e_inst_misaligned_i = 1'b0; e_illegal_inst_i = 1'b0; e_ebreak_i = 1'b0;
        e_ecall_i = 1'b0; e_ld_misaligned_i = 1'b0; e_st_misaligned_i = 1'b0;
    endtask

    task automatic wait_we(input int budget, output bit found, output obs_t o);
        found = 1'b0;
        o     = '0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (we_exc_o === 1'b1) begin
                found = 1'b1;
                o     = snap();
            end
        end
    endtask

    task automatic test_reset();
        obs_t o;
        o = snap();
        checks++;
        if (o !== '0 || mip_d_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h mip %h, want all zero", o, mip_d_o);
        end
    endtask

    task automatic test_illegal();
        obs_t o, e;
        bit   found;
        @(negedge clk);
        valid_i = 1'b1; e_illegal_inst_i = 1'b1; pc_i = 32'h100; inst_i = 32'hFFFF_FFFF;
        mstatus_i = 32'h8;
        exp_q.push_back(mk(1'b0, 1'b0, 32'd2, 32'h100, 32'hFFFF_FFFF, 32'h1880));
        wait_we(1, found, o);
        clear_inputs();
        e = exp_q.pop_front();
        checks++;
        if (!found || o !== e) begin
            errors++;
            $display("FAIL illegal_enter: found %0d got %h want %h", found, o, e);
        end
        @(negedge clk);
        checks++;
        if (flush_o !== 1'b1 || we_exc_o !== 1'b0 || redirect_o !== 1'b0 || is_int_o !== 1'b0 ||
            sel_exc_nret_o !== 1'b0 || mcause_d_o !== 32'd2) begin
            errors++;
            $display("FAIL illegal_drain: flush %b we %b redir %b mcause %h, want flush 1 strobes 0 mcause 2",
                     flush_o, we_exc_o, redirect_o, mcause_d_o);
        end
        @(negedge clk);
        checks++;
        if (flush_o !== 1'b0 || mepc_d_o !== 32'h100) begin
            errors++;
            $display("FAIL illegal_idle: flush %b mepc %h, want flush 0 mepc 100", flush_o, mepc_d_o);
        end
    endtask

    task automatic test_timer_irq();
        obs_t o, e;
        bit   found;
        @(negedge clk);
        mstatus_i = 32'h8; mie_i = 32'h80; irq_timer_i = 1'b1; valid_i = 1'b1; pc_i = 32'h200;
        exp_q.push_back(mk(1'b1, 1'b0, 32'h8000_0007, 32'h200, 32'h0, 32'h1880));
        wait_we(5, found, o);
        clear_inputs();
        e = exp_q.pop_front();
        checks++;
        if (!found || o !== e) begin
            errors++;
            $display("FAIL timer_enter: found %0d got %h want %h", found, o, e);
        end
        checks++;
        if (mip_d_o !== 32'h80) begin
            errors++;
            $display("FAIL timer_mip: got %h want 00000080", mip_d_o);
        end
        irq_timer_i = 1'b0; mie_i = '0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_masked_irq();
        bit seen = 1'b0;
        @(negedge clk);
        mstatus_i = 32'h0; mie_i = 32'h80; irq_timer_i = 1'b1; valid_i = 1'b1; pc_i = 32'h200;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (we_exc_o !== 1'b0 || flush_o !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL masked_no_trap: strobe seen 1, want 0");
        end
        checks++;
        if (mip_d_o !== 32'h80) begin
            errors++;
            $display("FAIL masked_mip: got %h want 00000080", mip_d_o);
        end
        clear_inputs();
        irq_timer_i = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (mip_d_o !== 32'h0) begin
            errors++;
            $display("FAIL irq_dropped_mip: got %h want 00000000", mip_d_o);
        end
        mie_i = '0; mstatus_i = '0;
    endtask

    task automatic test_simultaneous();
        obs_t o, e;
        bit   found;
        // ecall against an already-pending external interrupt
        mstatus_i = 32'h8; mie_i = 32'h800; irq_ext_i = 1'b1;
        repeat (3) @(negedge clk);
        valid_i = 1'b1; e_ecall_i = 1'b1; pc_i = 32'h300;
        exp_q.push_back(mk(1'b1, 1'b0, 32'h8000_000B, 32'h300, 32'h0, 32'h1880));
        wait_we(1, found, o);
        clear_inputs();
        e = exp_q.pop_front();
        checks++;
        if (!found || o !== e) begin
            errors++;
            $display("FAIL ext_over_ecall: found %0d got %h want %h", found, o, e);
        end
        repeat (2) @(negedge clk);
        // ext and timer both pending
        mie_i = 32'h880; irq_timer_i = 1'b1;
        repeat (3) @(negedge clk);
        valid_i = 1'b1; pc_i = 32'h310;
        exp_q.push_back(mk(1'b1, 1'b0, 32'h8000_000B, 32'h310, 32'h0, 32'h1880));
        wait_we(1, found, o);
        clear_inputs();
        e = exp_q.pop_front();
        checks++;
        if (!found || o !== e || mip_d_o !== 32'h880) begin
            errors++;
            $display("FAIL ext_over_timer: found %0d got %h mip %h want %h mip 00000880", found, o, mip_d_o, e);
        end
        repeat (2) @(negedge clk);
        // sw beats timer
        irq_ext_i = 1'b0; irq_sw_i = 1'b1; mie_i = 32'h88;
        repeat (3) @(negedge clk);
        valid_i = 1'b1; pc_i = 32'h320;
        exp_q.push_back(mk(1'b1, 1'b0, 32'h8000_0003, 32'h320, 32'h0, 32'h1880));
        wait_we(1, found, o);
        clear_inputs();
        e = exp_q.pop_front();
        checks++;
        if (!found || o !== e) begin
            errors++;
            $display("FAIL sw_over_timer: found %0d got %h want %h", found, o, e);
        end
        irq_sw_i = 1'b0; irq_timer_i = 1'b0; mie_i = '0;
        repeat (4) @(negedge clk);
        // exception beats mret
        valid_i = 1'b1; e_ecall_i = 1'b1; is_mret_i = 1'b1; pc_i = 32'h330; mstatus_i = 32'h8;
        exp_q.push_back(mk(1'b0, 1'b0, 32'd11, 32'h330, 32'h0, 32'h1880));
        wait_we(1, found, o);
        clear_inputs();
        e = exp_q.pop_front();
        checks++;
        if (!found || o !== e) begin
            errors++;
            $display("FAIL ecall_over_mret: found %0d got %h want %h", found, o, e);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_exc_priority();
        obs_t o, e;
        bit   found;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            valid_i = 1'b1; pc_i = 32'h400 + 32'(i * 4); inst_i = 32'hDEAD_BEEF;
            badaddr_i = 32'h0000_1234; mstatus_i = 32'h0;
            {e_inst_misaligned_i, e_illegal_inst_i, e_ebreak_i, e_ecall_i,
             e_ld_misaligned_i, e_st_misaligned_i} = prio_flags[i];
            exp_q.push_back(mk(1'b0, 1'b0, prio_cause[i], 32'h400 + 32'(i * 4), prio_tval[i], 32'h1800));
            wait_we(1, found, o);
            clear_inputs();
            e = exp_q.pop_front();
            checks++;
            if (!found || o !== e) begin
                errors++;
                $display("FAIL exc_prio_%0d: found %0d got %h want %h", i, found, o, e);
            end
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic test_mret();
        obs_t o, e;
        bit   found;
        @(negedge clk);
        valid_i = 1'b1; is_mret_i = 1'b1; mstatus_i = 32'h1880; mepc_i = 32'h104;
        mcause_i = 32'h2; mtval_i = 32'h55; pc_i = 32'h900;
        exp_q.push_back(mk(1'b0, 1'b1, 32'h2, 32'h104, 32'h55, 32'h1888));
        wait_we(1, found, o);
        clear_inputs();
        e = exp_q.pop_front();
        checks++;
        if (!found || o !== e) begin
            errors++;
            $display("FAIL mret_enter: found %0d got %h want %h", found, o, e);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        obs_t o, e;
        bit   found;
        @(negedge clk);
        valid_i = 1'b1; e_ecall_i = 1'b1; pc_i = 32'h500; mstatus_i = 32'h8; inst_i = 32'h1234_5678;
        exp_q.push_back(mk(1'b0, 1'b0, 32'd11, 32'h500, 32'h0, 32'h1880));
        wait_we(1, found, o);
        // Second exception held from the ENTER cycle onward
        e_ecall_i = 1'b0; e_illegal_inst_i = 1'b1; pc_i = 32'h504;
        e = exp_q.pop_front();
        checks++;
        if (!found || o !== e) begin
            errors++;
            $display("FAIL b2b_first: found %0d got %h want %h", found, o, e);
        end
        @(negedge clk);
        checks++;
        if (we_exc_o !== 1'b0 || flush_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ignored_drain: we %b flush %b, want we 0 flush 1", we_exc_o, flush_o);
        end
        @(negedge clk);
        checks++;
        if (we_exc_o !== 1'b0 || flush_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: we %b flush %b, want 0 0", we_exc_o, flush_o);
        end
        exp_q.push_back(mk(1'b0, 1'b0, 32'd2, 32'h504, 32'h1234_5678, 32'h1880));
        wait_we(1, found, o);
        clear_inputs();
        e = exp_q.pop_front();
        checks++;
        if (!found || o !== e) begin
            errors++;
            $display("FAIL b2b_second: found %0d got %h want %h", found, o, e);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_in_enter();
        obs_t o, e;
        bit   found;
        mie_i = 32'h0; irq_sw_i = 1'b1;
        repeat (3) @(negedge clk);
        valid_i = 1'b1; e_ecall_i = 1'b1; pc_i = 32'h600; mstatus_i = 32'h8;
        exp_q.push_back(mk(1'b0, 1'b0, 32'd11, 32'h600, 32'h0, 32'h1880));
        wait_we(1, found, o);
        clear_inputs();
        e = exp_q.pop_front();
        checks++;
        if (!found || o !== e || mip_d_o !== 32'h8) begin
            errors++;
            $display("FAIL rst_pre_enter: found %0d got %h mip %h want %h mip 00000008", found, o, mip_d_o, e);
        end
        #1 rst = 1'b1;
        #1;
        o = snap();
        checks++;
        if (o !== '0 || mip_d_o !== 32'h0) begin
            errors++;
            $display("FAIL rst_async_clear: got %h mip %h, want all zero", o, mip_d_o);
        end
        irq_sw_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (flush_o !== 1'b0 || we_exc_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_after_idle: flush %b we %b, want 0 0", flush_o, we_exc_o);
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        pc_i = '0; inst_i = '0; badaddr_i = '0;
        irq_ext_i = 1'b0; irq_timer_i = 1'b0; irq_sw_i = 1'b0;
        mstatus_i = '0; mie_i = '0; mepc_i = '0; mcause_i = '0; mtval_i = '0;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_illegal();
        test_timer_irq();
        test_masked_irq();
        test_simultaneous();
        test_exc_priority();
        test_mret();
        test_back_to_back();
        test_reset_in_enter();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drained: %0d entries left, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
